// File: rtl/morse_symbol_classifier.sv
// rtl/morse_symbol_classifier.sv - debounced key level to DIT/DAH/GAP/SPACE/ERR symbol stream
`timescale 1ns/1ps
module morse_symbol_classifier #(
  parameter int WIDTH     = 16,
  parameter int DEBOUNCE  = 4,
  parameter int DIT_MAX   = 1000,
  parameter int DAH_MAX   = 3000,
  parameter int GAP_MIN   = 2000,
  parameter int SPACE_MIN = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       signal,
  output logic [2:0] ditsdahs,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic       overrun,
  input  logic       clr_ovr
);

  localparam logic [2:0] SYM_WAIT  = 3'd0;
  localparam logic [2:0] SYM_DIT   = 3'd1;
  localparam logic [2:0] SYM_DAH   = 3'd2;
  localparam logic [2:0] SYM_GAP   = 3'd3;
  localparam logic [2:0] SYM_SPACE = 3'd4;
  localparam logic [2:0] SYM_ERR   = 3'd5;

  localparam int DBW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DBW-1:0]   DB_LAST   = DBW'(DEBOUNCE - 1);
  localparam logic [WIDTH-1:0] CNT_MAX   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] GAP_CNT   = WIDTH'(GAP_MIN);
  localparam logic [WIDTH-1:0] SPACE_CNT = WIDTH'(SPACE_MIN);

  typedef enum logic [2:0] {IDLE, MARK, SPC, SPC_GAP, SPC_WORD} state_t;

  state_t           state;
  logic             sync1, sync2, sig_f;
  logic [DBW-1:0]   db_cnt;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cap;
  logic [31:0]      cap_ext;
  logic             flip;
  logic             emit;
  logic [2:0]       emit_code;
  logic [2:0]       mark_code;

  // sig_f toggles on the cycle the synchronised level has disagreed for DEBOUNCE cycles
  assign flip    = (sync2 != sig_f) && (db_cnt == DB_LAST);
  assign cap_ext = 32'(cap);

  // two-flop synchroniser followed by the consecutive-disagreement debouncer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sig_f  <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync1 <= signal;
      sync2 <= sync1;
      if (sync2 != sig_f) begin
        if (db_cnt == DB_LAST) begin
          sig_f  <= sync2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // cnt is the 1-based length of the current sig_f level; cap keeps the finished level's length
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      cap <= '0;
    end else if (flip) begin
      cnt <= WIDTH'(1);
      cap <= cnt;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  // classification of the captured mark length; a saturated count is always an error
  always_comb begin
    mark_code = SYM_DIT;
    if ((cap == CNT_MAX) || (cap_ext > 32'(DAH_MAX))) begin
      mark_code = SYM_ERR;
    end else if (cap_ext > 32'(DIT_MAX)) begin
      mark_code = SYM_DAH;
    end
  end

  // symbol emission decided from the current state, filtered level and counter
  always_comb begin
    emit      = 1'b0;
    emit_code = SYM_WAIT;
    case (state)
      MARK: begin
        if (!sig_f) begin
          emit      = 1'b1;
          emit_code = mark_code;
        end
      end
      SPC: begin
        if (!sig_f && (cnt == GAP_CNT)) begin
          emit      = 1'b1;
          emit_code = SYM_GAP;
        end
      end
      SPC_GAP: begin
        if (!sig_f && (cnt == SPACE_CNT)) begin
          emit      = 1'b1;
          emit_code = SYM_SPACE;
        end
      end
      default: begin
        emit      = 1'b0;
        emit_code = SYM_WAIT;
      end
    endcase
  end

  // state sequencing plus the single-entry output holding register and sticky overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ditsdahs  <= SYM_WAIT;
      sym_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      case (state)
        IDLE:     if (sig_f) state <= MARK;
        MARK:     if (!sig_f) state <= SPC;
        SPC: begin
          if (sig_f)               state <= MARK;
          else if (cnt == GAP_CNT) state <= SPC_GAP;
        end
        SPC_GAP: begin
          if (sig_f)                 state <= MARK;
          else if (cnt == SPACE_CNT) state <= SPC_WORD;
        end
        SPC_WORD: if (sig_f) state <= MARK;
        default:  state <= IDLE;
      endcase

      if (emit && (!sym_valid || sym_ready)) begin
        ditsdahs  <= emit_code;
        sym_valid <= 1'b1;
      end else if (sym_valid && sym_ready) begin
        ditsdahs  <= SYM_WAIT;
        sym_valid <= 1'b0;
      end

      if (emit && sym_valid && !sym_ready) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_morse_symbol_classifier.sv
// tb/tb_morse_symbol_classifier.sv - self-checking bench for morse_symbol_classifier
`timescale 1ns/1ps
module tb_morse_symbol_classifier;

  localparam int GAP_MIN   = 20;
  localparam int SPACE_MIN = 50;
  localparam int LAT_EDGE  = 4;   // 2 sync flops + DEBOUNCE cycles to reach sig_f

  localparam logic [2:0] SYM_WAIT  = 3'd0;
  localparam logic [2:0] SYM_DIT   = 3'd1;
  localparam logic [2:0] SYM_DAH   = 3'd2;
  localparam logic [2:0] SYM_GAP   = 3'd3;
  localparam logic [2:0] SYM_SPACE = 3'd4;
  localparam logic [2:0] SYM_ERR   = 3'd5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       signal = 1'b0;
  logic       sym_ready = 1'b1;
  logic       clr_ovr = 1'b0;
  logic [2:0] ditsdahs;
  logic       sym_valid;
  logic       overrun;

  int cyc = 0;
  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [2:0] code;
    int         at;     // handshake cycle, -1 = don't care
  } exp_t;

  typedef struct {
    int         mark;
    int         low;
    logic [2:0] code;
    bit         gap;
    bit         space;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];

  morse_symbol_classifier #(
    .WIDTH(8), .DEBOUNCE(2), .DIT_MAX(10), .DAH_MAX(30),
    .GAP_MIN(GAP_MIN), .SPACE_MIN(SPACE_MIN)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .signal(signal),
    .ditsdahs(ditsdahs),
    .sym_valid(sym_valid),
    .sym_ready(sym_ready),
    .overrun(overrun),
    .clr_ovr(clr_ovr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // scoreboard: every completed handshake must match the oldest expected symbol
  always @(negedge clk) begin
    if (sym_valid && sym_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_symbol", int'(ditsdahs) + 8 * int'(sym_valid), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sym_code", int'(ditsdahs), int'(e.code));
        if (e.at >= 0) check("sym_cycle", cyc, e.at);
      end
    end
  end

  task automatic hold(input logic v, input int n);
    signal = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int f;
    hold(1'b1, v.mark);
    f = cyc;
    sb.push_back('{code: v.code, at: f + LAT_EDGE + 1});
    if (v.gap)   sb.push_back('{code: SYM_GAP,   at: f + LAT_EDGE + GAP_MIN});
    if (v.space) sb.push_back('{code: SYM_SPACE, at: f + LAT_EDGE + SPACE_MIN});
    hold(1'b0, v.low);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int f;
    int guard;

    vecs[0] = '{mark: 8,   low: 60, code: SYM_DIT, gap: 1'b1, space: 1'b1};
    vecs[1] = '{mark: 10,  low: 12, code: SYM_DIT, gap: 1'b0, space: 1'b0};
    vecs[2] = '{mark: 11,  low: 12, code: SYM_DAH, gap: 1'b0, space: 1'b0};
    vecs[3] = '{mark: 30,  low: 12, code: SYM_DAH, gap: 1'b0, space: 1'b0};
    vecs[4] = '{mark: 31,  low: 12, code: SYM_ERR, gap: 1'b0, space: 1'b0};
    vecs[5] = '{mark: 300, low: 25, code: SYM_ERR, gap: 1'b1, space: 1'b0};
    vecs[6] = '{mark: 5,   low: 19, code: SYM_DIT, gap: 1'b0, space: 1'b0};
    vecs[7] = '{mark: 5,   low: 20, code: SYM_DIT, gap: 1'b1, space: 1'b0};
    vecs[8] = '{mark: 5,   low: 49, code: SYM_DIT, gap: 1'b1, space: 1'b0};
    vecs[9] = '{mark: 5,   low: 50, code: SYM_DIT, gap: 1'b1, space: 1'b1};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", int'(sym_valid), 0);
    check("reset_code", int'(ditsdahs), int'(SYM_WAIT));
    check("reset_overrun", int'(overrun), 0);
    rst_n = 1'b1;
    hold(1'b0, 5);

    foreach (vecs[i]) run_vec(vecs[i]);

    // one-cycle low glitch inside a 25-cycle mark
    hold(1'b1, 12);
    hold(1'b0, 1);
    hold(1'b1, 12);
    f = cyc;
    sb.push_back('{code: SYM_DAH,   at: f + LAT_EDGE + 1});
    sb.push_back('{code: SYM_GAP,   at: f + LAT_EDGE + GAP_MIN});
    sb.push_back('{code: SYM_SPACE, at: f + LAT_EDGE + SPACE_MIN});
    hold(1'b0, 60);

    // consumer stalled across DIT then GAP: GAP dropped, overrun sticky until cleared
    sym_ready = 1'b0;
    hold(1'b1, 8);
    sb.push_back('{code: SYM_DIT, at: -1});
    hold(1'b0, 30);
    check("stall_valid", int'(sym_valid), 1);
    check("stall_code", int'(ditsdahs), int'(SYM_DIT));
    check("stall_overrun", int'(overrun), 1);
    clr_ovr = 1'b1;
    @(posedge clk);
    #1;
    clr_ovr = 1'b0;
    check("clr_overrun", int'(overrun), 0);
    sym_ready = 1'b1;
    hold(1'b0, 2);
    check("stall_drained", int'(sym_valid), 0);

    // handshake of the held DIT in the very cycle GAP is emitted
    sym_ready = 1'b0;
    hold(1'b1, 8);
    f = cyc;
    sb.push_back('{code: SYM_DIT, at: f + LAT_EDGE + GAP_MIN - 1});
    sb.push_back('{code: SYM_GAP, at: f + LAT_EDGE + GAP_MIN});
    hold(1'b0, LAT_EDGE + GAP_MIN - 1);
    sym_ready = 1'b1;
    hold(1'b0, 30 - (LAT_EDGE + GAP_MIN - 1));
    check("coincident_overrun", int'(overrun), 0);

    // reset 15 cycles into the low after a DIT held by a stalled consumer
    sym_ready = 1'b0;
    hold(1'b1, 8);
    hold(1'b0, 15);
    rst_n = 1'b0;
    hold(1'b0, 2);
    check("midrst_valid", int'(sym_valid), 0);
    check("midrst_code", int'(ditsdahs), int'(SYM_WAIT));
    check("midrst_overrun", int'(overrun), 0);
    rst_n = 1'b1;
    sym_ready = 1'b1;
    hold(1'b0, 70);
    check("midrst_no_gap", int'(sym_valid), 0);
    run_vec(vecs[0]);

    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    #1;
    check("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
